// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Memory pipeline stage. Issues load/store requests over a
//             valid/ready handshake, stalls upstream while a request is in
//             flight, aligns/extends load data and registers writeback fields.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MEM_MASK_WIDTH  = 3,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Flush,
  input  logic [ADDRESS_WIDTH-1:0]   i_ALU_Result,
  input  logic                       i_Mem_Valid,
  input  logic [MEM_MASK_WIDTH-1:0]  i_Mem_Mask,
  input  logic                       i_Mem_Read_Write_n,
  input  logic [DATA_WIDTH-1:0]      i_Mem_Write_Data,
  input  logic                       i_Writes_Back,
  input  logic [REG_ADDR_WIDTH:0]    i_PWrite_Addr,
  input  logic [FREE_LIST_WIDTH-1:0] i_Phys_Active_List_Index,
  output logic                       o_Stall_Request,
  output logic                       o_DMem_Valid,
  input  logic                       i_DMem_Ready,
  output logic [ADDRESS_WIDTH-1:0]   o_DMem_Address,
  output logic                       o_DMem_Read_Write_n,
  output logic [3:0]                 o_DMem_Byte_En,
  output logic [DATA_WIDTH-1:0]      o_DMem_Write_Data,
  input  logic [DATA_WIDTH-1:0]      i_DMem_Read_Data,
  output logic                       o_WB_Valid,
  output logic [DATA_WIDTH-1:0]      o_WB_Data,
  output logic [REG_ADDR_WIDTH:0]    o_WB_PWrite_Addr,
  output logic [FREE_LIST_WIDTH-1:0] o_WB_Active_List_Index,
  output logic                       o_Misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_t                       state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
  logic [3:0]                   be_q, be_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic                         rw_q, rw_d;
  logic [1:0]                   size_q, size_d;
  logic                         zext_q, zext_d;
  logic [1:0]                   lo_q, lo_d;
  logic [REG_ADDR_WIDTH:0]      dest_q, dest_d;
  logic [FREE_LIST_WIDTH-1:0]   tag_q, tag_d;
  logic                         flush_pend_q, flush_pend_d;
  logic                         wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0]        wb_data_q, wb_data_d;
  logic [REG_ADDR_WIDTH:0]      wb_dest_q, wb_dest_d;
  logic [FREE_LIST_WIDTH-1:0]   wb_tag_q, wb_tag_d;
  logic                         misal_q, misal_d;

  logic [1:0]                   size_in;
  logic                         misal_in;
  logic [3:0]                   be_in;
  logic [DATA_WIDTH-1:0]        wdata_in;
  logic [DATA_WIDTH-1:0]        lane;
  logic [DATA_WIDTH-1:0]        load_data;
  logic                         stall;

  // Decode size, alignment, lane enables and replicated store data of the incoming op
  always_comb begin
    size_in  = i_Mem_Mask[1:0];
    misal_in = 1'b0;
    be_in    = 4'b1111;
    wdata_in = i_Mem_Write_Data;
    if (size_in == SZ_BYTE) begin
      be_in    = 4'b0001 << i_ALU_Result[1:0];
      wdata_in = {4{i_Mem_Write_Data[7:0]}};
    end else if (size_in == SZ_HALF) begin
      misal_in = i_ALU_Result[0];
      be_in    = i_ALU_Result[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{i_Mem_Write_Data[15:0]}};
    end else begin
      // Reserved size code 11 behaves as a word access
      misal_in = (i_ALU_Result[1:0] != 2'b00);
    end
  end

  // Select the addressed lane of the returned word and sign/zero extend it
  always_comb begin
    lane      = i_DMem_Read_Data >> {lo_q, 3'b000};
    load_data = lane;
    if (size_q == SZ_BYTE) begin
      load_data = {{24{lane[7] & ~zext_q}}, lane[7:0]};
    end else if (size_q == SZ_HALF) begin
      load_data = {{16{lane[15] & ~zext_q}}, lane[15:0]};
    end
  end

  // Next-state and output logic of the request FSM
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    size_d       = size_q;
    zext_d       = zext_q;
    lo_d         = lo_q;
    dest_d       = dest_q;
    tag_d        = tag_q;
    flush_pend_d = flush_pend_q;
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    wb_dest_d    = wb_dest_q;
    wb_tag_d     = wb_tag_q;
    misal_d      = 1'b0;
    stall        = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (i_Flush) begin
          wb_valid_d = 1'b0;
        end else if (i_Mem_Valid && !misal_in) begin
          state_d    = REQ;
          stall      = 1'b1;
          addr_d     = {i_ALU_Result[ADDRESS_WIDTH-1:2], 2'b00};
          be_d       = be_in;
          wdata_d    = wdata_in;
          rw_d       = i_Mem_Read_Write_n;
          size_d     = size_in;
          zext_d     = i_Mem_Mask[2];
          lo_d       = i_ALU_Result[1:0];
          dest_d     = i_PWrite_Addr;
          tag_d      = i_Phys_Active_List_Index;
          wb_valid_d = 1'b0;
        end else begin
          // Non-memory pass-through; a misaligned memory op lands here too
          wb_valid_d = i_Writes_Back & ~i_Mem_Valid;
          wb_data_d  = i_ALU_Result;
          wb_dest_d  = i_PWrite_Addr;
          wb_tag_d   = i_Phys_Active_List_Index;
          misal_d    = i_Mem_Valid;
        end
      end
      REQ: begin
        stall        = 1'b1;
        flush_pend_d = flush_pend_q | i_Flush;
        if (i_DMem_Ready) begin
          state_d      = DONE;
          flush_pend_d = 1'b0;
          wb_valid_d   = rw_q & i_Writes_Back & ~(flush_pend_q | i_Flush);
          wb_data_d    = load_data;
          wb_dest_d    = dest_q;
          wb_tag_d     = tag_q;
        end
      end
      DONE: begin
        // EX/MEM advances at this edge; the inputs seen now are stale
        state_d    = IDLE;
        wb_valid_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        wb_valid_d = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      size_q       <= '0;
      zext_q       <= 1'b0;
      lo_q         <= '0;
      dest_q       <= '0;
      tag_q        <= '0;
      flush_pend_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      wb_tag_q     <= '0;
      misal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      zext_q       <= zext_d;
      lo_q         <= lo_d;
      dest_q       <= dest_d;
      tag_q        <= tag_d;
      flush_pend_q <= flush_pend_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_dest_q    <= wb_dest_d;
      wb_tag_q     <= wb_tag_d;
      misal_q      <= misal_d;
    end
  end

  assign o_Stall_Request        = stall;
  assign o_DMem_Valid           = (state_q == REQ);
  assign o_DMem_Address         = addr_q;
  assign o_DMem_Read_Write_n    = rw_q;
  assign o_DMem_Byte_En         = be_q;
  assign o_DMem_Write_Data      = wdata_q;
  assign o_WB_Valid             = wb_valid_q;
  assign o_WB_Data              = wb_data_q;
  assign o_WB_PWrite_Addr       = wb_dest_q;
  assign o_WB_Active_List_Index = wb_tag_q;
  assign o_Misaligned           = misal_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit (directed + random ops
//             against an arithmetic reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] alu;
  logic        mem_valid;
  logic [2:0]  mask;
  logic        rw_n;
  logic [31:0] wdata;
  logic        writes_back;
  logic [5:0]  pdest;
  logic [2:0]  ptag;
  logic        stall;
  logic        dm_valid;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic        dm_rw_n;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [5:0]  wb_dest;
  logic [2:0]  wb_tag;
  logic        misal;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .i_Clk                    (clk),
    .i_Reset                  (rst),
    .i_Flush                  (flush),
    .i_ALU_Result             (alu),
    .i_Mem_Valid              (mem_valid),
    .i_Mem_Mask               (mask),
    .i_Mem_Read_Write_n       (rw_n),
    .i_Mem_Write_Data         (wdata),
    .i_Writes_Back            (writes_back),
    .i_PWrite_Addr            (pdest),
    .i_Phys_Active_List_Index (ptag),
    .o_Stall_Request          (stall),
    .o_DMem_Valid             (dm_valid),
    .i_DMem_Ready             (dm_ready),
    .o_DMem_Address           (dm_addr),
    .o_DMem_Read_Write_n      (dm_rw_n),
    .o_DMem_Byte_En           (dm_be),
    .o_DMem_Write_Data        (dm_wdata),
    .i_DMem_Read_Data         (dm_rdata),
    .o_WB_Valid               (wb_valid),
    .o_WB_Data                (wb_data),
    .o_WB_PWrite_Addr         (wb_dest),
    .o_WB_Active_List_Index   (wb_tag),
    .o_Misaligned             (misal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes (reserved code acts as word)
  function automatic int nbytes(input logic [2:0] m);
    case (m[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] m, input logic [31:0] a);
    int n = nbytes(m);
    int first = (n == 4) ? 0 : int'(a[1:0]) - (int'(a[1:0]) % n);
    logic [3:0] r = '0;
    for (int b = 0; b < 4; b++) if (b >= first && b < first + n) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] m, input logic [31:0] d);
    int n = nbytes(m);
    longint unsigned unit = longint'(d) % (64'd1 << (8 * n));
    longint unsigned r = 0;
    for (int k = 0; k < 4 / n; k++) r = r + (unit << (8 * n * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(m);
    longint unsigned span = 64'd1 << (8 * n);
    longint unsigned v = (longint'(rd) >> (8 * int'(a[1:0]))) % span;
    if (!m[2] && v >= span / 2) v = v + (64'h1_0000_0000 - span);
    return v[31:0];
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] m, input logic [31:0] a);
    int n = nbytes(m);
    return (int'(a[1:0]) % n) != 0;
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; mem_valid = 1'b0; writes_back = 1'b0; dm_ready = 1'b0;
  endtask

  // Non-memory op: result visible one cycle later, never stalls
  task automatic nonmem(input logic [31:0] a, input logic wb, input logic [5:0] d,
                        input logic [2:0] t, input logic fl);
    @(negedge clk);
    idle_inputs();
    alu = a; writes_back = wb; pdest = d; ptag = t; flush = fl;
    mem_valid = 1'b0;
    #1 chk("nm_stall", stall, 0);
    @(negedge clk);
    idle_inputs();
    #1 chk("nm_wb_valid", wb_valid, wb & ~fl);
    if (!fl) begin
      chk("nm_wb_data", wb_data, a);
      chk("nm_wb_dest", wb_dest, d);
      chk("nm_wb_tag", wb_tag, t);
    end
    chk("nm_misal", misal, 0);
  endtask

  // Misaligned memory op: one-cycle exception pulse, no request, no stall
  task automatic misal_op(input logic [31:0] a, input logic [2:0] m, input logic r);
    @(negedge clk);
    alu = a; mask = m; rw_n = r; mem_valid = 1'b1; writes_back = 1'b1; flush = 1'b0;
    #1 chk("mis_stall", stall, 0);
    @(negedge clk);
    idle_inputs();
    #1 chk("mis_pulse", misal, 1);
    chk("mis_wb_valid", wb_valid, 0);
    chk("mis_dm_valid", dm_valid, 0);
    @(negedge clk);
    #1 chk("mis_pulse_end", misal, 0);
  endtask

  // Aligned load/store with a given number of wait cycles; flush_at<0 means no flush
  task automatic mem_op(input logic [31:0] a, input logic [2:0] m, input logic r,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic wb, input logic [5:0] d, input logic [2:0] t,
                        input int flush_at);
    logic exp_v;
    @(negedge clk);
    idle_inputs();
    alu = a; mask = m; rw_n = r; wdata = wd; mem_valid = 1'b1;
    writes_back = wb; pdest = d; ptag = t;
    #1 chk("acc_stall", stall, 1);
    chk("acc_dm_valid", dm_valid, 0);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      flush    = (w == flush_at);
      dm_ready = (w == waits);
      dm_rdata = (w == waits) ? rd : $urandom;
      #1 chk("req_valid", dm_valid, 1);
      chk("req_stall", stall, 1);
      chk("req_addr", dm_addr, {a[31:2], 2'b00});
      chk("req_rw", dm_rw_n, r);
      chk("req_be", dm_be, ref_be(m, a));
      chk("req_wdata", dm_wdata, ref_wdata(m, wd));
    end
    @(negedge clk);
    flush = 1'b0; dm_ready = 1'b0; dm_rdata = $urandom;
    exp_v = r & wb & (flush_at < 0);
    #1 chk("done_stall", stall, 0);
    chk("done_dm_valid", dm_valid, 0);
    chk("done_wb_valid", wb_valid, exp_v);
    if (exp_v) begin
      chk("done_wb_data", wb_data, ref_load(m, a, rd));
      chk("done_wb_dest", wb_dest, d);
      chk("done_wb_tag", wb_tag, t);
    end
    @(negedge clk);
    idle_inputs();
    #1 chk("post_wb_valid", wb_valid, 0);
    chk("post_stall", stall, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  m;
    int          kind;

    rst = 1'b1; idle_inputs();
    alu = '0; mask = '0; rw_n = 1'b0; wdata = '0; pdest = '0; ptag = '0; dm_rdata = '0;
    repeat (2) @(negedge clk);
    #1 chk("rst_stall", stall, 0);
    chk("rst_dm_valid", dm_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_misal", misal, 0);
    chk("rst_dm_addr", dm_addr, 0);
    rst = 1'b0;

    // Directed cases
    nonmem(32'h0000_1234, 1'b1, 6'd9, 3'd5, 1'b0);
    mem_op(32'h103, 3'b000, 1'b1, 32'h0, 32'h80FF_FF00, 3, 1'b1, 6'd3, 3'd1, -1);
    mem_op(32'h103, 3'b100, 1'b1, 32'h0, 32'h80FF_FF00, 3, 1'b1, 6'd3, 3'd1, -1);
    mem_op(32'h206, 3'b001, 1'b0, 32'h0000_ABCD, 32'h0, 0, 1'b1, 6'd4, 3'd2, -1);
    misal_op(32'h102, 3'b010, 1'b1);
    mem_op(32'h300, 3'b010, 1'b1, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 6'd7, 3'd6, 1);
    nonmem(32'h5555_AAAA, 1'b1, 6'd1, 3'd1, 1'b1);

    // Reset while a request is outstanding
    @(negedge clk);
    alu = 32'h400; mask = 3'b010; rw_n = 1'b1; mem_valid = 1'b1; writes_back = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1 chk("rreq_valid", dm_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("rreq_dm_valid", dm_valid, 0);
    chk("rreq_stall", stall, 0);
    chk("rreq_dm_addr", dm_addr, 0);
    chk("rreq_dm_be", dm_be, 0);
    chk("rreq_wb_valid", wb_valid, 0);
    rst = 1'b0;

    // Random mix of operations
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      m    = 3'($urandom);
      a    = $urandom;
      if (kind == 0) begin
        nonmem($urandom, 1'($urandom), 6'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0));
      end else if (kind == 3 && m[1:0] != 2'b00) begin
        if (!ref_misaligned(m, a)) a[0] = 1'b1;
        misal_op(a, m, 1'($urandom));
      end else begin
        a[1:0] = a[1:0] & ~2'(nbytes(m) - 1);
        mem_op(a, m, (kind != 2), $urandom, $urandom, $urandom_range(0, 4),
               1'($urandom), 6'($urandom), 3'($urandom),
               ($urandom_range(0, 5) == 0) ? 0 : -1);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
